// File: rtl/pc_update_unit_pkg.sv
// Shared core constants and types for the next-PC selection logic.
//   XLEN             - datapath width in bits
//   INSTR_BYTES      - size of one instruction; sequential flow advances by this much
//   RESET_PC_DEFAULT - default address loaded into the registered PC on reset
//   pc_sel_e         - which candidate address the priority mux picks
package pc_update_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    SelSeq,
    SelJalr,
    SelRel
  } pc_sel_e;

endpackage

// File: rtl/pc_target_adder.sv
// Branch/jump target adder: base + offset, modulo 2^XLEN.
// The offset is a two's complement immediate, so a plain wrap-around add is exact.
//   base_i   - base address (pc or rs1)
//   offset_i - sign-extended byte offset
//   sum_o    - wrapped sum
module pc_target_adder
  import pc_update_unit_pkg::*;
(
  input  logic [XLEN-1:0] base_i,
  input  logic [XLEN-1:0] offset_i,
  output logic [XLEN-1:0] sum_o
);

  assign sum_o = base_i + offset_i;

endmodule

// File: rtl/pc_update_unit.sv
// Next-program-counter selector for the single-cycle RV32I core.
// Picks the next fetch address from sequential flow, JAL, JALR and taken branches,
// and keeps a registered copy of that address.
//   clk, rst     - clock; synchronous active-high reset of pc_reg only
//   rs1_data     - JALR base
//   jump         - JAL or JALR
//   jalr_enable  - selects JALR when jump is set (ignored otherwise)
//   branch, zero - conditional branch and its taken flag
//   pc_address   - PC of the current instruction
//   imm          - sign-extended, pre-scaled byte offset
//   next_pc      - combinational next fetch address
//   pc_plus4     - link value for JAL/JALR
//   redirect     - control flow leaves the sequential path
//   misaligned   - next_pc is not word aligned (informational)
//   pc_reg       - next_pc captured on each rising edge
module pc_update_unit
  import pc_update_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            jump,
  input  logic            jalr_enable,
  input  logic            branch,
  input  logic [XLEN-1:0] pc_address,
  input  logic [XLEN-1:0] imm,
  input  logic            zero,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic            misaligned,
  output logic [XLEN-1:0] pc_reg
);

  localparam logic [XLEN-1:0] LsbMask = ~{{(XLEN-1){1'b0}}, 1'b1};

  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] pc_q;
  pc_sel_e         sel;

  pc_target_adder u_jalr_adder (
    .base_i   (rs1_data),
    .offset_i (imm),
    .sum_o    (jalr_sum)
  );

  pc_target_adder u_rel_adder (
    .base_i   (pc_address),
    .offset_i (imm),
    .sum_o    (rel_target)
  );

  // JALR drops bit 0 of the computed target; nothing else is realigned.
  assign jalr_target = jalr_sum & LsbMask;

  assign pc_plus4 = pc_address + XLEN'(INSTR_BYTES);

  // Priority: JALR, then JAL, then taken branch. jalr_enable alone selects nothing.
  always_comb begin
    sel = SelSeq;
    if (jump && jalr_enable) begin
      sel = SelJalr;
    end else if (jump) begin
      sel = SelRel;
    end else if (branch && zero) begin
      sel = SelRel;
    end
  end

  always_comb begin
    next_pc = pc_plus4;
    case (sel)
      SelJalr: next_pc = jalr_target;
      SelRel:  next_pc = rel_target;
      default: next_pc = pc_plus4;
    endcase
  end

  assign redirect   = jump | (branch & zero);
  assign misaligned = |next_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= next_pc;
    end
  end

  assign pc_reg = pc_q;

endmodule

// File: tb/tb_pc_update_unit.sv
module tb_pc_update_unit;

  localparam logic [31:0] TbResetPc = 32'hA5A5_0000;

  typedef struct {
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic        misaligned;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] rs1_data;
  logic        jump;
  logic        jalr_enable;
  logic        branch;
  logic [31:0] pc_address;
  logic [31:0] imm;
  logic        zero;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        misaligned;
  logic [31:0] pc_reg;

  exp_t        comb_q[$];
  logic [31:0] reg_q[$];

  int n_cmp = 0;
  int n_err = 0;

  pc_update_unit #(
    .RESET_PC (TbResetPc)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_data    (rs1_data),
    .jump        (jump),
    .jalr_enable (jalr_enable),
    .branch      (branch),
    .pc_address  (pc_address),
    .imm         (imm),
    .zero        (zero),
    .next_pc     (next_pc),
    .pc_plus4    (pc_plus4),
    .redirect    (redirect),
    .misaligned  (misaligned),
    .pc_reg      (pc_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction's inputs and queue the expected combinational outputs.
  task automatic drive_vec(input logic j, input logic je, input logic b, input logic z,
                           input logic [31:0] r1, input logic [31:0] pc,
                           input logic [31:0] im, input logic [31:0] exp_next,
                           input logic exp_redir);
    exp_t e;
    jump        = j;
    jalr_enable = je;
    branch      = b;
    zero        = z;
    rs1_data    = r1;
    pc_address  = pc;
    imm         = im;
    e.next_pc    = exp_next;
    e.pc_plus4   = pc + 32'd4;
    e.redirect   = exp_redir;
    e.misaligned = (exp_next[1:0] != 2'b00);
    comb_q.push_back(e);
  endtask

  task automatic test_reset();
    logic [31:0] exp_reg;
    @(negedge clk);
    rst = 1'b1;
    drive_vec(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 32'h0, 32'h0000_0014, 1'b0);
    reg_q.push_back(TbResetPc);
    @(posedge clk);
    #1;
    exp_reg = reg_q.pop_front();
    n_cmp++;
    if (pc_reg !== exp_reg) begin
      n_err++;
      $display("FAIL reset pc_reg: got %h want %h", pc_reg, exp_reg);
    end
    // Combinational path must ignore rst.
    begin
      exp_t e;
      e = comb_q.pop_front();
      n_cmp++;
      if (next_pc !== e.next_pc) begin
        n_err++;
        $display("FAIL reset next_pc under rst: got %h want %h", next_pc, e.next_pc);
      end
    end
  endtask

  task automatic test_comb(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      case (tag)
        "sequential": case (i)
          0: drive_vec(0, 0, 0, 0, 32'h0, 32'h0000_0000, 32'h0, 32'h0000_0004, 0);
          1: drive_vec(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 0);
          default: drive_vec(0, 0, 0, 1, 32'h0, 32'h0000_1234, 32'h40, 32'h0000_1238, 0);
        endcase
        "jalr": case (i)
          0: drive_vec(1, 1, 0, 0, 32'h1000, 32'h0000_9000, 32'h20, 32'h0000_1020, 1);
          1: drive_vec(1, 1, 0, 0, 32'h2000, 32'h0000_9000, 32'hFFFF_FFF0, 32'h0000_1FF0, 1);
          default: drive_vec(1, 1, 0, 0, 32'h1000, 32'h0000_9000, 32'h3, 32'h0000_1002, 1);
        endcase
        "jal": case (i)
          0: drive_vec(1, 0, 0, 0, 32'h7777, 32'h0000_0080, 32'h100, 32'h0000_0180, 1);
          1: drive_vec(1, 0, 0, 0, 32'h7777, 32'h0000_0200, 32'hFFFF_FE00, 32'h0000_0000, 1);
          default: drive_vec(1, 0, 0, 0, 32'h7777, 32'h0000_0080, 32'h2, 32'h0000_0082, 1);
        endcase
        "branch": case (i)
          0: drive_vec(0, 0, 1, 1, 32'h0, 32'h0000_0400, 32'h40, 32'h0000_0440, 1);
          1: drive_vec(0, 0, 1, 0, 32'h0, 32'h0000_0800, 32'h80, 32'h0000_0804, 0);
          default: drive_vec(0, 0, 1, 1, 32'h0, 32'h0000_0010, 32'hFFFF_FFF0, 32'h0, 1);
        endcase
        default: case (i)
          0: drive_vec(1, 1, 1, 1, 32'h2000, 32'h0000_5000, 32'h10, 32'h0000_2010, 1);
          1: drive_vec(1, 0, 1, 1, 32'h9999, 32'h0000_3000, 32'h20, 32'h0000_3020, 1);
          default: drive_vec(0, 1, 0, 0, 32'h4000, 32'h0000_0100, 32'h8, 32'h0000_0104, 0);
        endcase
      endcase
      #1;
      e = comb_q.pop_front();
      n_cmp++;
      if (next_pc !== e.next_pc) begin
        n_err++;
        $display("FAIL %s[%0d] next_pc: got %h want %h", tag, i, next_pc, e.next_pc);
      end
      n_cmp++;
      if (pc_plus4 !== e.pc_plus4) begin
        n_err++;
        $display("FAIL %s[%0d] pc_plus4: got %h want %h", tag, i, pc_plus4, e.pc_plus4);
      end
      n_cmp++;
      if (redirect !== e.redirect) begin
        n_err++;
        $display("FAIL %s[%0d] redirect: got %b want %b", tag, i, redirect, e.redirect);
      end
      n_cmp++;
      if (misaligned !== e.misaligned) begin
        n_err++;
        $display("FAIL %s[%0d] misaligned: got %b want %b", tag, i, misaligned, e.misaligned);
      end
      #4;
    end
  endtask

  // Registered PC across consecutive cycles, including a reset in the middle.
  task automatic test_back_to_back();
    exp_t        e;
    logic [31:0] exp_reg;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rst = (i == 6);
      case (i)
        0: drive_vec(0, 0, 0, 0, 32'h0, 32'h0000_0010, 32'h0, 32'h0000_0014, 0);
        1: drive_vec(1, 0, 0, 0, 32'h0, 32'h0000_0014, 32'h100, 32'h0000_0114, 1);
        2: drive_vec(0, 0, 1, 1, 32'h0, 32'h0000_0114, 32'hFFFF_FFF8, 32'h0000_010C, 1);
        3: drive_vec(0, 0, 1, 0, 32'h0, 32'h0000_010C, 32'hFFFF_FFF8, 32'h0000_0110, 0);
        4: drive_vec(1, 1, 0, 0, 32'h5001, 32'h0000_0110, 32'h0, 32'h0000_5000, 1);
        5: drive_vec(0, 0, 0, 0, 32'h0, 32'h0000_5000, 32'h0, 32'h0000_5004, 0);
        6: drive_vec(1, 0, 0, 0, 32'h0, 32'h0000_5004, 32'h80, 32'h0000_5084, 1);
        default: drive_vec(0, 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, 0);
      endcase
      reg_q.push_back(i == 6 ? TbResetPc : comb_q[comb_q.size()-1].next_pc);
      @(posedge clk);
      #1;
      e = comb_q.pop_front();
      exp_reg = reg_q.pop_front();
      n_cmp++;
      if (next_pc !== e.next_pc) begin
        n_err++;
        $display("FAIL back_to_back[%0d] next_pc: got %h want %h", i, next_pc, e.next_pc);
      end
      n_cmp++;
      if (pc_reg !== exp_reg) begin
        n_err++;
        $display("FAIL back_to_back[%0d] pc_reg: got %h want %h", i, pc_reg, exp_reg);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    rs1_data    = '0;
    jump        = 1'b0;
    jalr_enable = 1'b0;
    branch      = 1'b0;
    pc_address  = '0;
    imm         = '0;
    zero        = 1'b0;

    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_comb("sequential", 3);
    test_comb("jalr", 3);
    test_comb("jal", 3);
    test_comb("branch", 3);
    test_comb("priority", 3);
    test_back_to_back();

    if (comb_q.size() != 0 || reg_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard drain: got %0d/%0d left want 0/0", comb_q.size(), reg_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
